rx_chan_sched: RTL and testbench
================================

Name: rx_chan_sched

Overview:
Write-side controller for the RX sample FIFO in the rx_clk domain. On each rxstrobe it captures the enabled 16-bit channel samples and packs them two per 32-bit FIFO word, low half first, to match the LSB-first SPI shifter. It drives wrreq and data into the dual-clock FIFO and generates have_pkt_rdy and a sticky rx_overrun. Its channel-enable mask is set over the serial register bus.

Parameters:
PKT_WORDS, 12'd128, FIFO write level (words) at or above which have_pkt_rdy asserts
REG_ADDR, 7'd40, serial_addr of the config register
LVL_W, 12, width of the FIFO used-words count

Ports:
rx_clk  in  1  sole clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
serial_addr  in  7  register bus address
serial_data  in  32  register bus data
serial_strobe  in  1  one-cycle register write strobe
rxstrobe  in  1  one-cycle sample-valid pulse
ch_0, ch_1, ch_2, ch_3  in  16 each  channel samples, valid with rxstrobe
clear_status  in  1  one-cycle clear of rx_overrun
wr_fifo_full  in  1  FIFO write-side full flag
wr_fifo_level  in  LVL_W  FIFO write-side used words
fifo_data  out  32  FIFO write data
fill_fifo  out  1  FIFO wrreq, one cycle per word
channels  out  4  active enable mask
have_pkt_rdy  out  1  FIFO holds at least PKT_WORDS words
rx_overrun  out  1  sticky; a sample or word was dropped

Behaviour:
- Reset values: fifo_data 0, fill_fifo 0, channels 0, have_pkt_rdy 0, rx_overrun 0, run 0, pending config 0, residue empty, state IDLE.
- Config register:
  - Written when serial_strobe=1 and serial_addr==REG_ADDR.
  - Bits [3:0] are the enable mask; bit 31 is run. Both are captured into pending registers.
  - Pending values are copied into channels/run only while in IDLE, on a cycle with no rxstrobe. Active config never changes mid sample-set.
  - Writing run=0 also clears the residue.
- States:
  - IDLE to PACK on rxstrobe when run=1 and channels!=0. On that cycle ch_0..ch_3 are latched and the enabled channels queued in ascending index order. Otherwise rxstrobe is ignored and no flag is set.
  - PACK emits one word per cycle while two or more 16-bit halves are available (queued samples plus residue). word = {later sample, earlier sample}; the earlier sample is in bits [15:0].
  - PACK to IDLE when fewer than two halves remain. A single leftover half becomes the residue and pairs with the first sample of the next set.
- Latency: rxstrobe at cycle N gives fill_fifo high at N+1 for the first word, then word k at N+1+k. The largest set is 4 channels plus residue, i.e. 2 words per set.
- rxstrobe while not IDLE: that sample set is dropped, rx_overrun is set, and the in-progress set completes normally. Required rxstrobe spacing is at least 3 cycles.
- FIFO full: if wr_fifo_full=1 on a cycle a word is due, fill_fifo stays 0 and rx_overrun is set. All remaining words of the set and the residue are discarded, then the block returns to IDLE.
- rx_overrun: sticky. clear_status clears it. If a set event and clear_status occur on the same cycle, set wins.
- have_pkt_rdy: registered each cycle as (wr_fifo_level >= PKT_WORDS); one cycle latency. Unsigned compare at LVL_W bits.
- fill_fifo is never high while wr_fifo_full=1 on the same cycle.
- reset asserted mid-operation clears all state immediately (asynchronous). No partial word is written after reset releases.

Decomposition:
- Shared package (rx_pkg): state encoding (IDLE, PACK), REG_ADDR constant, config bit positions (MASK_LSB=0, RUN_BIT=31), sample width 16.
- One natural sub-module: rx_half_packer, which pairs a stream of 16-bit halves into 32-bit words, holds the residue and supports a flush input. The top level holds config, queueing and the flags.

Test Plan:
- Mask 4'b1111, run=1; one rxstrobe with ch_0..3 = 1111/2222/3333/4444 -> fill_fifo at N+1 with 32'h22221111, at N+2 with 32'h44443333, then IDLE.
- Mask 4'b0101; two strobes with ch_0=A0, ch_2=A2, then ch_0=B0, ch_2=B2 -> words 32'h00A200A0, 32'h00B200B0. Mask 4'b0001 with three strobes s0, s1, s2 -> one word {s1,s0}, then s2 held as residue.
- wr_fifo_full=1 during a 4-channel set -> no fill_fifo pulse, rx_overrun=1. clear_status alone -> 0. clear_status on the same cycle as a new drop -> stays 1.
- rxstrobe at N and N+1 with mask 4'b1111 -> exactly 2 words written and rx_overrun=1.
- Mask written to 4'b0011 while in PACK -> channels updates only after IDLE. wr_fifo_level 127 then 128 -> have_pkt_rdy goes 0 then 1, one cycle after each level.
- reset pulsed during PACK -> all outputs 0 asynchronously. First word after re-enable contains no pre-reset residue.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and constants for the RX sample-FIFO write-side controller.
package rx_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } state_e;

    localparam logic [6:0] CFG_REG_ADDR = 7'd40;
    localparam int         MASK_LSB     = 0;
    localparam int         RUN_BIT      = 31;
    localparam int         NUM_CH       = 4;
    localparam int         SAMPLE_W     = 16;
    localparam int         WORD_W       = 2 * SAMPLE_W;
    // Worst case held: one residue half plus a full four-channel set.
    localparam int         HBUF_DEPTH   = NUM_CH + 1;

endpackage

// File: rtl/rx_half_packer.sv
// Pairs 16-bit halves into 32-bit words (earlier half in [15:0]) and keeps an odd leftover as residue.
// Word visible the cycle after load; pop consumes two halves; flush drops everything incl. residue.
module rx_half_packer
    import rx_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            load_i,
    input  logic [2:0]                      load_cnt_i,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0] load_halves_i,
    input  logic                            pop_i,
    output logic [WORD_W-1:0]               word_o,
    output logic                            word_vld_o,
    output logic [2:0]                      cnt_o
);

    logic [HBUF_DEPTH-1:0][SAMPLE_W-1:0] hbuf_q, hbuf_d;
    logic [2:0]                          cnt_q, cnt_d;
    logic [2:0]                          idx;

    always_comb begin
        hbuf_d = hbuf_q;
        cnt_d  = cnt_q;
        idx    = '0;
        if (flush_i) begin
            hbuf_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            // New halves append behind any residue so it pairs with the first new sample.
            for (int i = 0; i < NUM_CH; i++) begin
                if (3'(i) < load_cnt_i) begin
                    idx = cnt_q + 3'(i);
                    if (idx < 3'(HBUF_DEPTH)) begin
                        hbuf_d[idx] = load_halves_i[i];
                    end
                end
            end
            cnt_d = cnt_q + load_cnt_i;
        end else if (pop_i && (cnt_q >= 3'd2)) begin
            hbuf_d = '0;
            for (int i = 0; i < HBUF_DEPTH - 2; i++) begin
                hbuf_d[i] = hbuf_q[i+2];
            end
            cnt_d = cnt_q - 3'd2;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hbuf_q <= '0;
            cnt_q  <= '0;
        end else begin
            hbuf_q <= hbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o     = {hbuf_q[1], hbuf_q[0]};
    assign word_vld_o = (cnt_q >= 3'd2);
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/rx_chan_sched.sv
// RX FIFO write controller: captures enabled channels on rxstrobe, packs two per word, flags overrun.
// First word one cycle after rxstrobe; on wr_fifo_full the rest of the set and the residue are dropped.
module rx_chan_sched
    import rx_pkg::*;
#(
    parameter int               LVL_W     = 12,
    parameter logic [LVL_W-1:0] PKT_WORDS = 12'd128,
    parameter logic [6:0]       REG_ADDR  = CFG_REG_ADDR
) (
    input  logic              rx_clk,
    input  logic              reset,
    input  logic [6:0]        serial_addr,
    input  logic [31:0]       serial_data,
    input  logic              serial_strobe,
    input  logic              rxstrobe,
    input  logic [15:0]       ch_0,
    input  logic [15:0]       ch_1,
    input  logic [15:0]       ch_2,
    input  logic [15:0]       ch_3,
    input  logic              clear_status,
    input  logic              wr_fifo_full,
    input  logic [LVL_W-1:0]  wr_fifo_level,
    output logic [31:0]       fifo_data,
    output logic              fill_fifo,
    output logic [3:0]        channels,
    output logic              have_pkt_rdy,
    output logic              rx_overrun
);

    state_e                          state_q, state_d;
    logic [NUM_CH-1:0]               channels_q, pend_mask_q;
    logic                            run_q, pend_run_q;
    logic                            ovr_q, ovr_d;
    logic                            pkt_rdy_q;

    logic                            cfg_wr;
    logic                            apply_cfg, load, pop, flush, fill, set_ovr;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] ch_arr, ld_halves;
    logic [2:0]                      ld_cnt;
    logic [WORD_W-1:0]               pk_word;
    logic                            pk_word_vld;
    logic [2:0]                      pk_cnt;
    logic                            unused_cfg_bits;

    assign cfg_wr          = serial_strobe && (serial_addr == REG_ADDR);
    assign unused_cfg_bits = ^serial_data[RUN_BIT-1:MASK_LSB+NUM_CH];
    assign ch_arr          = {ch_3, ch_2, ch_1, ch_0};

    always_comb begin
        ld_halves = '0;
        ld_cnt    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (channels_q[i]) begin
                ld_halves[ld_cnt[1:0]] = ch_arr[i];
                ld_cnt                 = ld_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        apply_cfg = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        fill      = 1'b0;
        set_ovr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rxstrobe && run_q && (channels_q != '0)) begin
                    load    = 1'b1;
                    state_d = ST_PACK;
                end else if (!rxstrobe) begin
                    apply_cfg = 1'b1;
                    flush     = !pend_run_q;
                end
            end
            ST_PACK: begin
                set_ovr = rxstrobe;
                if (!pk_word_vld) begin
                    state_d = ST_IDLE;
                end else if (wr_fifo_full) begin
                    set_ovr = 1'b1;
                    flush   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    fill = 1'b1;
                    pop  = 1'b1;
                    // Leave as the last pair goes out so a strobe 3 cycles later is accepted.
                    if (pk_cnt < 3'd4) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ovr_d = set_ovr ? 1'b1 : (clear_status ? 1'b0 : ovr_q);
    end

    always_ff @(posedge rx_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            channels_q  <= '0;
            run_q       <= 1'b0;
            pend_mask_q <= '0;
            pend_run_q  <= 1'b0;
            ovr_q       <= 1'b0;
            pkt_rdy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ovr_q     <= ovr_d;
            pkt_rdy_q <= (wr_fifo_level >= PKT_WORDS);
            if (cfg_wr) begin
                pend_mask_q <= serial_data[MASK_LSB +: NUM_CH];
                pend_run_q  <= serial_data[RUN_BIT];
            end
            if (apply_cfg) begin
                channels_q <= pend_mask_q;
                run_q      <= pend_run_q;
            end
        end
    end

    rx_half_packer u_packer (
        .clk_i         (rx_clk),
        .rst_i         (reset),
        .flush_i       (flush),
        .load_i        (load),
        .load_cnt_i    (ld_cnt),
        .load_halves_i (ld_halves),
        .pop_i         (pop),
        .word_o        (pk_word),
        .word_vld_o    (pk_word_vld),
        .cnt_o         (pk_cnt)
    );

    assign fill_fifo    = fill;
    assign fifo_data    = fill ? pk_word : '0;
    assign channels     = channels_q;
    assign have_pkt_rdy = pkt_rdy_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_rx_chan_sched.sv
// Directed bench for rx_chan_sched: per-cycle vector table plus hand sequences for config timing, level flag and reset.
module tb_rx_chan_sched;

    logic        rx_clk = 1'b0;
    logic        reset;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;
    logic        rxstrobe;
    logic [15:0] ch_0, ch_1, ch_2, ch_3;
    logic        clear_status;
    logic        wr_fifo_full;
    logic [11:0] wr_fifo_level;
    logic [31:0] fifo_data;
    logic        fill_fifo;
    logic [3:0]  channels;
    logic        have_pkt_rdy;
    logic        rx_overrun;

    int checks = 0;
    int errors = 0;

    always #5 rx_clk = ~rx_clk;

    rx_chan_sched dut (
        .rx_clk        (rx_clk),
        .reset         (reset),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .rxstrobe      (rxstrobe),
        .ch_0          (ch_0),
        .ch_1          (ch_1),
        .ch_2          (ch_2),
        .ch_3          (ch_3),
        .clear_status  (clear_status),
        .wr_fifo_full  (wr_fifo_full),
        .wr_fifo_level (wr_fifo_level),
        .fifo_data     (fifo_data),
        .fill_fifo     (fill_fifo),
        .channels      (channels),
        .have_pkt_rdy  (have_pkt_rdy),
        .rx_overrun    (rx_overrun)
    );

    typedef struct {
        logic        sstb;
        logic [6:0]  saddr;
        logic [31:0] sdat;
        logic        rxs;
        logic [15:0] c0, c1, c2, c3;
        logic        full;
        logic        clr;
        logic        efill;
        logic [31:0] edata;
        logic        eov;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic sstb, input logic [6:0] saddr, input logic [31:0] sdat,
                       input logic rxs, input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] c2, input logic [15:0] c3, input logic full,
                       input logic clr, input logic efill, input logic [31:0] edata,
                       input logic eov);
        vec_t v;
        v.sstb = sstb; v.saddr = saddr; v.sdat = sdat; v.rxs = rxs;
        v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
        v.full = full; v.clr = clr; v.efill = efill; v.edata = edata; v.eov = eov;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic full, input logic clr, input logic efill,
                        input logic [31:0] edata, input logic eov);
        add(1'b0, 7'd40, 32'h0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, full, clr, efill, edata, eov);
    endtask

    task automatic stb(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                       input logic [15:0] c3, input logic eov);
        add(1'b0, 7'd40, 32'h0, 1'b1, c0, c1, c2, c3, 1'b0, 1'b0, 1'b0, 32'h0, eov);
    endtask

    task automatic cfgv(input logic [6:0] addr, input logic [31:0] data, input logic eov);
        add(1'b1, addr, data, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0, eov);
    endtask

    task automatic step();
        @(posedge rx_clk);
        #1;
        serial_strobe = 1'b0;
        serial_addr   = 7'd40;
        rxstrobe      = 1'b0;
        clear_status  = 1'b0;
        wr_fifo_full  = 1'b0;
    endtask

    task automatic do_cfg(input logic [31:0] data);
        step();
        serial_strobe = 1'b1;
        serial_data   = data;
        step();
    endtask

    task automatic strobe4(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        step();
        rxstrobe = 1'b1;
        ch_0 = a; ch_1 = b; ch_2 = c; ch_3 = d;
    endtask

    initial begin
        reset = 1'b1;
        serial_addr = 7'd40; serial_data = '0; serial_strobe = 1'b0;
        rxstrobe = 1'b0; ch_0 = '0; ch_1 = '0; ch_2 = '0; ch_3 = '0;
        clear_status = 1'b0; wr_fifo_full = 1'b0; wr_fifo_level = '0;

        // Strobes ignored while not running, then a write to the wrong address.
        stb(16'h1, 16'h2, 16'h3, 16'h4, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        cfgv(7'd41, 32'h8000_000F, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h1, 16'h2, 16'h3, 16'h4, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        // All four channels.
        cfgv(7'd40, 32'h8000_000F, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
        idle(0, 0, 1, 32'h2222_1111, 0);
        idle(0, 0, 1, 32'h4444_3333, 0);
        idle(0, 0, 0, 32'h0, 0);
        // Back-to-back strobes: second set dropped.
        stb(16'h5555, 16'h6666, 16'h7777, 16'h8888, 1'b0);
        add(1'b0, 7'd40, 32'h0, 1'b1, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC,
            1'b0, 1'b0, 1'b1, 32'h6666_5555, 1'b0);
        idle(0, 0, 1, 32'h8888_7777, 1);
        idle(0, 0, 0, 32'h0, 1);
        idle(0, 1, 0, 32'h0, 1);
        idle(0, 0, 0, 32'h0, 0);
        // FIFO full drops the whole set.
        stb(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
        idle(1, 0, 0, 32'h0, 0);
        idle(0, 0, 0, 32'h0, 1);
        idle(0, 0, 0, 32'h0, 1);
        idle(0, 1, 0, 32'h0, 1);
        idle(0, 0, 0, 32'h0, 0);
        // Drop and clear on the same cycle: set wins.
        stb(16'h0001, 16'h0002, 16'h0003, 16'h0004, 1'b0);
        idle(1, 1, 0, 32'h0, 0);
        idle(0, 0, 0, 32'h0, 1);
        idle(0, 1, 0, 32'h0, 1);
        idle(0, 0, 0, 32'h0, 0);
        // Mask 0101.
        cfgv(7'd40, 32'h8000_0005, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h00A0, 16'h1111, 16'h00A2, 16'h2222, 1'b0);
        idle(0, 0, 1, 32'h00A2_00A0, 0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h00B0, 16'h3333, 16'h00B2, 16'h4444, 1'b0);
        idle(0, 0, 1, 32'h00B2_00B0, 0);
        idle(0, 0, 0, 32'h0, 0);
        // Mask 0001: residue carries across sets.
        cfgv(7'd40, 32'h8000_0001, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h0101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h0202, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(0, 0, 1, 32'h0202_0101, 0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h0303, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        idle(0, 0, 0, 32'h0, 0);
        // Residue s2 pairs with the next set's first sample.
        cfgv(7'd40, 32'h8000_0003, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h0404, 16'h0505, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(0, 0, 1, 32'h0404_0303, 0);
        idle(0, 0, 0, 32'h0, 0);
        // run=0 discards residue 0505.
        cfgv(7'd40, 32'h0000_0003, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h0E0E, 16'h0E0E, 16'h0E0E, 16'h0E0E, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        cfgv(7'd40, 32'h8000_000F, 1'b0);
        idle(0, 0, 0, 32'h0, 0);
        stb(16'h1001, 16'h2002, 16'h3003, 16'h4004, 1'b0);
        idle(0, 0, 1, 32'h2002_1001, 0);
        idle(0, 0, 1, 32'h4004_3003, 0);
        idle(0, 0, 0, 32'h0, 0);

        // Reset state.
        @(posedge rx_clk);
        #2;
        chk("reset fill_fifo", {31'd0, fill_fifo}, 32'd0);
        chk("reset fifo_data", fifo_data, 32'd0);
        chk("reset channels", {28'd0, channels}, 32'd0);
        chk("reset have_pkt_rdy", {31'd0, have_pkt_rdy}, 32'd0);
        chk("reset rx_overrun", {31'd0, rx_overrun}, 32'd0);
        step();
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step();
            serial_strobe = tbl[i].sstb;
            serial_addr   = tbl[i].saddr;
            serial_data   = tbl[i].sdat;
            rxstrobe      = tbl[i].rxs;
            ch_0 = tbl[i].c0; ch_1 = tbl[i].c1; ch_2 = tbl[i].c2; ch_3 = tbl[i].c3;
            wr_fifo_full  = tbl[i].full;
            clear_status  = tbl[i].clr;
            @(negedge rx_clk);
            chk($sformatf("row%0d fill_fifo", i), {31'd0, fill_fifo}, {31'd0, tbl[i].efill});
            if (tbl[i].efill) begin
                chk($sformatf("row%0d fifo_data", i), fifo_data, tbl[i].edata);
            end
            chk($sformatf("row%0d rx_overrun", i), {31'd0, rx_overrun}, {31'd0, tbl[i].eov});
        end

        // Mask written mid-set takes effect only back in IDLE.
        strobe4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        step();
        serial_strobe = 1'b1;
        serial_data   = 32'h8000_0003;
        @(negedge rx_clk);
        chk("midset word0", fifo_data, 32'h0002_0001);
        step();
        @(negedge rx_clk);
        chk("midset channels pack", {28'd0, channels}, 32'h0000_000F);
        step();
        @(negedge rx_clk);
        chk("midset channels idle", {28'd0, channels}, 32'h0000_000F);
        step();
        @(negedge rx_clk);
        chk("midset channels applied", {28'd0, channels}, 32'h0000_0003);

        // have_pkt_rdy threshold with one cycle latency.
        step();
        wr_fifo_level = 12'd127;
        @(negedge rx_clk);
        chk("pkt_rdy initial", {31'd0, have_pkt_rdy}, 32'd0);
        step();
        wr_fifo_level = 12'd128;
        @(negedge rx_clk);
        chk("pkt_rdy at 127", {31'd0, have_pkt_rdy}, 32'd0);
        step();
        @(negedge rx_clk);
        chk("pkt_rdy at 128", {31'd0, have_pkt_rdy}, 32'd1);
        step();
        wr_fifo_level = 12'd127;
        @(negedge rx_clk);
        chk("pkt_rdy lag", {31'd0, have_pkt_rdy}, 32'd1);
        step();
        @(negedge rx_clk);
        chk("pkt_rdy back to 127", {31'd0, have_pkt_rdy}, 32'd0);
        step();
        wr_fifo_level = 12'hFFF;
        step();
        @(negedge rx_clk);
        chk("pkt_rdy at max", {31'd0, have_pkt_rdy}, 32'd1);

        // Reset mid-set with overrun set, pkt_rdy high and a residue pending.
        strobe4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        step();
        wr_fifo_full = 1'b1;
        @(negedge rx_clk);
        chk("full blocks fill", {31'd0, fill_fifo}, 32'd0);
        step();
        @(negedge rx_clk);
        chk("full sets overrun", {31'd0, rx_overrun}, 32'd1);
        do_cfg(32'h8000_0001);
        strobe4(16'h0BAD, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        step();
        do_cfg(32'h8000_000F);
        strobe4(16'h0C0C, 16'h0D0D, 16'h0E0E, 16'h0F0F);
        step();
        #1;
        chk("pre-reset residue word", fifo_data, 32'h0C0C_0BAD);
        #1;
        reset = 1'b1;
        #1;
        chk("async fill_fifo", {31'd0, fill_fifo}, 32'd0);
        chk("async fifo_data", fifo_data, 32'd0);
        chk("async channels", {28'd0, channels}, 32'd0);
        chk("async have_pkt_rdy", {31'd0, have_pkt_rdy}, 32'd0);
        chk("async rx_overrun", {31'd0, rx_overrun}, 32'd0);
        step();
        step();
        reset = 1'b0;
        @(negedge rx_clk);
        chk("post-reset fill_fifo", {31'd0, fill_fifo}, 32'd0);
        do_cfg(32'h8000_0001);
        strobe4(16'h0C01, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        @(negedge rx_clk);
        chk("no stale residue", {31'd0, fill_fifo}, 32'd0);
        step();
        step();
        strobe4(16'h0C02, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        step();
        @(negedge rx_clk);
        chk("post-reset fill", {31'd0, fill_fifo}, 32'd1);
        chk("post-reset word", fifo_data, 32'h0C02_0C01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
